// File: rtl/armored66_rx_bringup_if.sv
// armored66_rx_bringup_if
//   Groups the lock-status inputs, the retrain request and the reset/status
//   outputs of the receive bring-up sequencer.
//   master : the side that reports lock status and requests retrains
//            (the receive datapath plus management logic, or a testbench)
//   slave  : the bring-up sequencer itself
//
// Signalling: there is no valid/ready handshake on this bundle. Every signal is
// a level. The lock inputs may change at any time relative to clk100. retrain is
// sampled on clk100, and only its rising edge has meaning. All outputs are
// registered on clk100 and stay valid from one edge to the next.
`timescale 1ns/1ps
interface armored66_rx_bringup_if #(
    parameter int NUM_LN = 4
);
    logic [NUM_LN-1:0] rx_freqlock;
    logic [NUM_LN-1:0] rx_wordlock;
    logic              deskew_locked;
    logic              retrain;
    logic              rst_rxa;
    logic              rst_rxd;
    logic              link_up;
    logic              fault;
    logic [2:0]        state;
    logic [7:0]        retry_cnt;
    logic [7:0]        flap_cnt;

    modport master (
        output rx_freqlock, rx_wordlock, deskew_locked, retrain,
        input  rst_rxa, rst_rxd, link_up, fault, state, retry_cnt, flap_cnt
    );

    modport slave (
        input  rx_freqlock, rx_wordlock, deskew_locked, retrain,
        output rst_rxa, rst_rxd, link_up, fault, state, retry_cnt, flap_cnt
    );
endinterface

// File: rtl/armored66_rx_bringup.sv
// armored66_rx_bringup
//   Reset and bring-up sequencer for the armored 66-bit receive path. It holds
//   the analog and digital receive resets, then walks the lanes through
//   frequency lock, ECC word lock and cross-lane deskew lock. Lock loss is
//   handled with bounded timeouts and counted retries. Status is reported on
//   clk100.
//
// Ports:
//   clk100    management clock; the only clock
//   rst100_n  asynchronous active-low reset
//   bus       armored66_rx_bringup_if.slave:
//               rx_freqlock/rx_wordlock [NUM_LN], deskew_locked (asynchronous in)
//               retrain (clk100-synchronous in; a rising edge requests a retrain)
//               rst_rxa, rst_rxd, link_up, fault, state[3], retry_cnt[8],
//               flap_cnt[8] (registered out)
`timescale 1ns/1ps
module armored66_rx_bringup #(
    parameter int NUM_LN    = 4,
    parameter int RST_CNTR  = 16,
    parameter int TMO_BITS  = 20,
    parameter int DEB_BITS  = 4,
    parameter int MAX_RETRY = 7
) (
    input logic                  clk100,
    input logic                  rst100_n,
    armored66_rx_bringup_if.slave bus
);

    localparam int CW = (RST_CNTR > TMO_BITS) ? RST_CNTR : TMO_BITS;
    localparam logic [CW-1:0]       RST_END = CW'((1 << RST_CNTR) - 1);
    localparam logic [CW-1:0]       TMO_END = CW'((1 << TMO_BITS) - 1);
    localparam logic [DEB_BITS-1:0] DEB_END = DEB_BITS'((1 << DEB_BITS) - 1);
    localparam logic [7:0]          RETRY_LIM = 8'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_ARST   = 3'd0,
        ST_FLOCK  = 3'd1,
        ST_DRST   = 3'd2,
        ST_WLOCK  = 3'd3,
        ST_DESKEW = 3'd4,
        ST_UP     = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers. retrain is already on clk100 but goes through the
    // same two stages so that every decision input has the same latency; the
    // third stage exists only for rising-edge detection.
    // ------------------------------------------------------------------
    logic [NUM_LN-1:0] fl_s1, fl_s2;
    logic [NUM_LN-1:0] wl_s1, wl_s2;
    logic              dk_s1, dk_s2;
    logic              rt_s1, rt_s2, rt_s3;

    always_ff @(posedge clk100 or negedge rst100_n) begin
        if (!rst100_n) begin
            fl_s1 <= '0;
            fl_s2 <= '0;
            wl_s1 <= '0;
            wl_s2 <= '0;
            dk_s1 <= 1'b0;
            dk_s2 <= 1'b0;
            rt_s1 <= 1'b0;
            rt_s2 <= 1'b0;
            rt_s3 <= 1'b0;
        end else begin
            fl_s1 <= bus.rx_freqlock;
            fl_s2 <= fl_s1;
            wl_s1 <= bus.rx_wordlock;
            wl_s2 <= wl_s1;
            dk_s1 <= bus.deskew_locked;
            dk_s2 <= dk_s1;
            rt_s1 <= bus.retrain;
            rt_s2 <= rt_s1;
            rt_s3 <= rt_s2;
        end
    end

    logic fl, wl, dl, rt_edge;
    assign fl      = &fl_s2;
    assign wl      = &wl_s2;
    assign dl      = dk_s2;
    assign rt_edge = rt_s2 & ~rt_s3;

    // ------------------------------------------------------------------
    // State and bookkeeping registers
    // ------------------------------------------------------------------
    state_t              st_q, st_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DEB_BITS-1:0] deb_q, deb_d;
    logic [7:0]          retry_q, retry_d;
    logic [7:0]          flap_q, flap_d;
    logic                fault_q, fault_d;
    logic                rst_rxa_q, rst_rxd_q, link_up_q;
    logic                retry_ev, flap_ev;

    // Next-state decision. Within each state the checks are ordered by
    // priority: freqlock loss, then retrain edge, then timeout/debounce
    // (checked last so that forward progress on the same cycle wins).
    always_comb begin
        st_d     = st_q;
        retry_ev = 1'b0;
        flap_ev  = 1'b0;
        case (st_q)
            ST_ARST: begin
                if (cnt_q == RST_END) st_d = ST_FLOCK;
            end
            ST_FLOCK: begin
                if (rt_edge || fl) begin
                    st_d = ST_DRST;
                end else if (cnt_q == TMO_END) begin
                    st_d     = ST_ARST;
                    retry_ev = 1'b1;
                end
            end
            ST_DRST: begin
                // retrain is deliberately not looked at here: we are already
                // holding the digital reset.
                if (!fl) begin
                    st_d     = ST_ARST;
                    retry_ev = 1'b1;
                end else if (cnt_q == RST_END) begin
                    st_d = ST_WLOCK;
                end
            end
            ST_WLOCK: begin
                if (!fl) begin
                    st_d     = ST_ARST;
                    retry_ev = 1'b1;
                end else if (rt_edge) begin
                    st_d = ST_DRST;
                end else if (wl) begin
                    st_d = ST_DESKEW;
                end else if (cnt_q == TMO_END) begin
                    st_d     = ST_DRST;
                    retry_ev = 1'b1;
                end
            end
            ST_DESKEW: begin
                if (!fl) begin
                    st_d     = ST_ARST;
                    retry_ev = 1'b1;
                end else if (rt_edge) begin
                    st_d = ST_DRST;
                end else if (!wl) begin
                    // Word lock slipped: go back one step without charging a retry.
                    st_d = ST_WLOCK;
                end else if (dl) begin
                    st_d = ST_UP;
                end else if (cnt_q == TMO_END) begin
                    st_d     = ST_DRST;
                    retry_ev = 1'b1;
                end
            end
            ST_UP: begin
                if (!fl) begin
                    st_d    = ST_ARST;
                    flap_ev = 1'b1;
                end else if (rt_edge) begin
                    st_d    = ST_DRST;
                    flap_ev = 1'b1;
                end else if (!(wl && dl) && (deb_q == DEB_END)) begin
                    st_d    = ST_DRST;
                    flap_ev = 1'b1;
                end
            end
            default: begin
                // Codes 6 and 7 are unreachable; recover if one ever appears.
                st_d = ST_ARST;
            end
        endcase

        cnt_d = (st_d != st_q) ? '0 : cnt_q + 1'b1;

        // Debounce counts consecutive bad cycles while staying in UP.
        deb_d = (st_q == ST_UP && st_d == ST_UP && !(wl && dl)) ? deb_q + 1'b1 : '0;

        retry_d = retry_q;
        if (st_d == ST_UP && st_q != ST_UP) begin
            retry_d = 8'd0;
        end else if (retry_ev && retry_q != 8'hFF) begin
            retry_d = retry_q + 8'd1;
        end

        fault_d = fault_q | (retry_ev && (retry_d >= RETRY_LIM));

        flap_d = flap_q;
        if (flap_ev && flap_q != 8'hFF) flap_d = flap_q + 8'd1;
    end

    // Outputs are decoded from the next state so they change on the same edge
    // as the state register.
    always_ff @(posedge clk100 or negedge rst100_n) begin
        if (!rst100_n) begin
            st_q      <= ST_ARST;
            cnt_q     <= '0;
            deb_q     <= '0;
            retry_q   <= 8'd0;
            flap_q    <= 8'd0;
            fault_q   <= 1'b0;
            rst_rxa_q <= 1'b1;
            rst_rxd_q <= 1'b1;
            link_up_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            deb_q     <= deb_d;
            retry_q   <= retry_d;
            flap_q    <= flap_d;
            fault_q   <= fault_d;
            rst_rxa_q <= (st_d == ST_ARST);
            rst_rxd_q <= (st_d == ST_ARST) || (st_d == ST_FLOCK) || (st_d == ST_DRST);
            link_up_q <= (st_d == ST_UP);
        end
    end

    assign bus.rst_rxa   = rst_rxa_q;
    assign bus.rst_rxd   = rst_rxd_q;
    assign bus.link_up   = link_up_q;
    assign bus.fault     = fault_q;
    assign bus.state     = st_q;
    assign bus.retry_cnt = retry_q;
    assign bus.flap_cnt  = flap_q;

endmodule
